// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   diff;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, ovf
    );
    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, ovf
    );
`else
    modport master (
        output start, a, b, b_in,
        input  busy, done, diff
    );
    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in, LSB first. The result is {borrow_out, difference}.
// Define SUB_OVF_EN to add a registered two's-complement overflow flag (bus.ovf).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   diff_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_diff;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic             last_shift;

    assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // New bit enters at the MSB; the full WIDTH-bit word is complete on the last shift.
    assign res_d      = {bit_diff, res_q};
    assign last_shift = (cnt_q == CW'(WIDTH - 1));

`ifdef SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.b_in;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SUB_OVF_EN
                        // Sign bits are shifted out of a_q/b_q, so keep them separately.
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d[WIDTH-1:1];
                    cnt_q <= cnt_q + 1'b1;
                    if (last_shift) begin
                        diff_q  <= {br_d, res_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SUB_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
`ifdef SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
